// File: rtl/tmds_decoder.sv
// TMDS receive channel: word alignment by control-token bit-slip search, then
// decode of each aligned symbol into a data byte or a 2-bit control value.
module tmds_decoder #(
    parameter int unsigned LOCK_COUNT     = 128,
    parameter int unsigned SEARCH_TIMEOUT = 2048,
    parameter int unsigned LOSS_TIMEOUT   = 4096
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic [9:0] tmds_in,
    output logic [7:0] data_out,
    output logic [1:0] control_out,
    output logic       de_out,
    output logic       ctrl_valid_out,
    output logic       locked_out,
    output logic [3:0] offset_out,
    output logic       slip_out
);

    localparam int unsigned RUN_W   = $clog2(LOCK_COUNT + 1);
    localparam int unsigned GAP_MAX = (LOSS_TIMEOUT > SEARCH_TIMEOUT) ? LOSS_TIMEOUT : SEARCH_TIMEOUT;
    localparam int unsigned GAP_W   = $clog2(GAP_MAX + 1);

    typedef enum logic {
        SEARCH,
        LOCKED
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [9:0]       prev_q;
    logic [9:0]       sym_q;
    logic             sym_lock_q;
    logic [3:0]       offset;
    logic [3:0]       offset_nxt;
    logic [RUN_W-1:0] run_cnt;
    logic [RUN_W-1:0] run_nxt;
    logic [GAP_W-1:0] gap_cnt;
    logic [GAP_W-1:0] gap_nxt;
    logic             slip_nxt;
    logic [19:0]      cat;
    logic [9:0]       win;
    logic             is_tok;
    logic [1:0]       tok_val;
    logic [7:0]       d_in;
    logic [7:0]       dec;

    // Sliding 10-bit window over the previous and current raw words
    assign cat = {tmds_in, prev_q};
    assign win = 10'(cat >> offset);

    always_comb begin
        is_tok  = 1'b1;
        tok_val = 2'b00;
        case (sym_q)
            10'b1101010100: tok_val = 2'b00;
            10'b0010101011: tok_val = 2'b01;
            10'b0101010100: tok_val = 2'b10;
            10'b1010101011: tok_val = 2'b11;
            default:        is_tok  = 1'b0;
        endcase
    end

    // Undo the optional inversion, then the xor/xnor transition chain
    always_comb begin
        d_in   = sym_q[9] ? ~sym_q[7:0] : sym_q[7:0];
        dec    = 8'd0;
        dec[0] = d_in[0];
        for (int i = 1; i < 8; i++) begin
            dec[i] = sym_q[8] ? (d_in[i] ^ d_in[i-1]) : ~(d_in[i] ^ d_in[i-1]);
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state   <= SEARCH;
            offset  <= 4'd0;
            run_cnt <= '0;
            gap_cnt <= '0;
        end else begin
            state   <= state_nxt;
            offset  <= offset_nxt;
            run_cnt <= run_nxt;
            gap_cnt <= gap_nxt;
        end
    end

    // Alignment FSM; lock is checked before slip since a token clears the gap anyway
    always_comb begin
        state_nxt  = state;
        offset_nxt = offset;
        slip_nxt   = 1'b0;
        if (is_tok) begin
            run_nxt = (run_cnt == RUN_W'(LOCK_COUNT)) ? run_cnt : run_cnt + RUN_W'(1);
            gap_nxt = '0;
        end else begin
            run_nxt = '0;
            gap_nxt = (gap_cnt == GAP_W'(GAP_MAX)) ? gap_cnt : gap_cnt + GAP_W'(1);
        end
        case (state)
            SEARCH: begin
                if (run_cnt == RUN_W'(LOCK_COUNT)) begin
                    state_nxt = LOCKED;
                    run_nxt   = '0;
                    gap_nxt   = '0;
                end else if (gap_cnt == GAP_W'(SEARCH_TIMEOUT)) begin
                    offset_nxt = (offset == 4'd9) ? 4'd0 : offset + 4'd1;
                    slip_nxt   = 1'b1;
                    run_nxt    = '0;
                    gap_nxt    = '0;
                end
            end
            LOCKED: begin
                if (gap_cnt == GAP_W'(LOSS_TIMEOUT)) begin
                    state_nxt = SEARCH;
                    run_nxt   = '0;
                    gap_nxt   = '0;
                end
            end
            default: begin
                state_nxt = SEARCH;
            end
        endcase
    end

    // Pipeline and output registers; gating uses the lock state captured with sym_q
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            prev_q         <= 10'd0;
            sym_q          <= 10'd0;
            sym_lock_q     <= 1'b0;
            data_out       <= 8'd0;
            control_out    <= 2'd0;
            de_out         <= 1'b0;
            ctrl_valid_out <= 1'b0;
            locked_out     <= 1'b0;
            offset_out     <= 4'd0;
            slip_out       <= 1'b0;
        end else begin
            prev_q         <= tmds_in;
            sym_q          <= win;
            sym_lock_q     <= (state == LOCKED);
            data_out       <= dec;
            if (is_tok) begin
                control_out <= tok_val;
            end
            de_out         <= sym_lock_q & ~is_tok;
            ctrl_valid_out <= sym_lock_q & is_tok;
            locked_out     <= sym_lock_q;
            offset_out     <= offset_nxt;
            slip_out       <= slip_nxt;
        end
    end

endmodule
